// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the 2:1 valid/ready arbiter.
//   arb_state_t : output-stage FSM state (ST_EMPTY / ST_FULL)
//   SEL_RST     : reset value of sel, so that in0 wins the first tie
//   SRC0/SRC1   : source index encodings carried on sel / gnt_idx
package mux_arb_pkg;

    typedef enum logic [0:0] {
        ST_EMPTY,
        ST_FULL
    } arb_state_t;

    localparam logic SEL_RST = 1'b1;
    localparam logic SRC0    = 1'b0;
    localparam logic SRC1    = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Purely combinational 2-way grant logic.
// Ports:
//   req[1:0] in  : request per source (bit 0 = in0, bit 1 = in1)
//   last     in  : index of the most recently granted source
//   grant    out : some source is granted
//   gnt_idx  out : index of the granted source (valid when grant=1)
// Build option MUX_ARB_FAIR_EN: defined -> round-robin tie-break (the source
// that did not win last time); undefined -> fixed priority, in0 wins ties.
module rr_arb2
    import mux_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       gnt_idx
);

    always_comb begin
        grant   = |req;
        gnt_idx = SRC0;
        if (req == 2'b11) begin
`ifdef MUX_ARB_FAIR_EN
            gnt_idx = ~last;
`else
            gnt_idx = SRC0;
`endif
        end else if (req[1]) begin
            gnt_idx = SRC1;
        end
    end

`ifndef MUX_ARB_FAIR_EN
    // Fixed priority ignores the history input.
    logic unused_last;
    assign unused_last = last;
`endif

endmodule

// File: rtl/mux_2x1_arb.sv
// Two-input valid/ready arbiter feeding a one-entry registered output stage.
// Drives sel, the select line of the downstream 2:1 data mux.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   in0_valid/in0_data/in0_ready  : source 0 handshake
//   in1_valid/in1_data/in1_ready  : source 1 handshake
//   out_valid/out_data/out_ready  : registered output handshake
//   sel                           : source of the last accepted transfer
// Build option MUX_ARB_FAIR_EN selects round-robin (defined) or fixed
// in0-priority (undefined) tie-breaking; see rr_arb2.
module mux_2x1_arb
    import mux_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel
);

    arb_state_t       state_q;
    logic [WIDTH-1:0] data_q;
    logic             sel_q;

    logic             load;
    logic             grant;
    logic             gnt_idx;
    logic [WIDTH-1:0] gnt_data;

    rr_arb2 u_rr_arb2 (
        .req     ({in1_valid, in0_valid}),
        .last    (sel_q),
        .grant   (grant),
        .gnt_idx (gnt_idx)
    );

    // The output register can take new data when empty or being drained.
    assign load     = (state_q == ST_EMPTY) || out_ready;
    assign gnt_data = (gnt_idx == SRC1) ? in1_data : in0_data;

    // Readies are suppressed during reset: the stage is EMPTY then, so load
    // alone would otherwise accept a transfer that reset is about to discard.
    assign in0_ready = !rst && load && grant && (gnt_idx == SRC0);
    assign in1_ready = !rst && load && grant && (gnt_idx == SRC1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            sel_q   <= SEL_RST;
        end else if (load) begin
            if (grant) begin
                state_q <= ST_FULL;
                data_q  <= gnt_data;
                sel_q   <= gnt_idx;
            end else begin
                state_q <= ST_EMPTY;
            end
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign sel       = sel_q;

endmodule

// File: tb/tb_mux_2x1_arb.sv
// Directed, table-driven bench for mux_2x1_arb (WIDTH=1). Expectations
// follow the MUX_ARB_FAIR_EN setting of the build.
module tb_mux_2x1_arb;

`ifdef MUX_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in0_valid = 1'b0, in1_valid = 1'b0, out_ready = 1'b0;
    logic [0:0] in0_data = '0, in1_data = '0, out_data;
    logic in0_ready, in1_ready, out_valid, sel;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mux_2x1_arb #(.WIDTH(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_ready (in1_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .sel       (sel)
    );

    typedef struct {
        bit v0, d0, v1, d1, ordy;
        bit e_r0, e_r1, e_ov, e_od, e_sel;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit v0, d0, v1, d1, ordy, e_r0, e_r1, e_ov, e_od, e_sel);
        vec_t v;
        v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.ordy = ordy;
        v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_ov = e_ov; v.e_od = e_od; v.e_sel = e_sel;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input bit ov, input bit od, input bit s);
        chk({tag, ".out_valid"}, out_valid, ov);
        chk({tag, ".out_data"}, out_data[0], od);
        chk({tag, ".sel"}, sel, s);
    endtask

    task automatic chk_rdy(input string tag, input bit r0, input bit r1);
        chk({tag, ".in0_ready"}, in0_ready, r0);
        chk({tag, ".in1_ready"}, in1_ready, r1);
    endtask

    initial begin
        // Sequence: reset with both sources valid, then release.
        in0_valid = 1; in0_data = 1; in1_valid = 1; in1_data = 0; out_ready = 1;
        #1 chk_rdy("rst_hold", 0, 0);
        @(posedge clk); #1;
        chk_rdy("rst_edge", 0, 0);
        chk_out("rst_edge", 0, 0, 1);
        rst = 0;
        #1 chk_rdy("rst_rel", 1, 0);
        @(posedge clk); #1;
        chk_out("rst_rel", 1, 1, 0);

        // Clean asynchronous reset pulse between edges before the table.
        rst = 1;
        #1 chk_out("rst_pulse", 0, 0, 1);
        rst = 0;

        //  v0 d0 v1 d1 ordy | r0 r1 ov od sel
        add(1, 1, 1, 0, 1,   1, 0, 1, 1, 0);
        add(1, 1, 1, 0, 1,   FAIR ? 0 : 1, FAIR ? 1 : 0, 1, FAIR ? 0 : 1, FAIR ? 1 : 0);
        add(1, 1, 1, 0, 1,   1, 0, 1, 1, 0);
        add(1, 1, 1, 0, 1,   FAIR ? 0 : 1, FAIR ? 1 : 0, 1, FAIR ? 0 : 1, FAIR ? 1 : 0);
        add(0, 0, 1, 1, 1,   0, 1, 1, 1, 1);   // only in1
        add(0, 0, 1, 1, 1,   0, 1, 1, 1, 1);
        add(1, 0, 1, 0, 0,   0, 0, 1, 1, 1);   // stall x3
        add(1, 0, 1, 0, 0,   0, 0, 1, 1, 1);
        add(1, 0, 1, 0, 0,   0, 0, 1, 1, 1);
        add(1, 1, 1, 0, 1,   1, 0, 1, 1, 0);   // drain + load, tie after sel=1
        add(0, 0, 0, 0, 1,   0, 0, 0, 1, 0);   // empties, data holds
        add(0, 0, 0, 0, 0,   0, 0, 0, 1, 0);   // empty, nothing to take
        add(1, 0, 0, 0, 0,   1, 0, 1, 0, 0);   // empty loads without out_ready
        add(0, 0, 1, 1, 0,   0, 0, 1, 0, 0);   // full stall
        add(0, 0, 1, 1, 1,   0, 1, 1, 1, 1);
        add(1, 0, 1, 1, 1,   1, 0, 1, 0, 0);   // tie after sel=1 -> in0

        for (int i = 0; i < tbl.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            in0_valid = tbl[i].v0; in0_data = tbl[i].d0;
            in1_valid = tbl[i].v1; in1_data = tbl[i].d1;
            out_ready = tbl[i].ordy;
            #1 chk_rdy(tag, tbl[i].e_r0, tbl[i].e_r1);
            @(posedge clk); #1;
            chk_out(tag, tbl[i].e_ov, tbl[i].e_od, tbl[i].e_sel);
        end

        // Sequence: reset while FULL and stalled clears without a clock edge.
        in0_valid = 1; in0_data = 1; in1_valid = 1; in1_data = 1; out_ready = 0;
        #1 chk_rdy("stall", 0, 0);
        @(posedge clk); #1;
        chk_out("stall", 1, 0, 0);
        rst = 1;
        #1;
        chk_out("mid_rst", 0, 0, 1);
        chk_rdy("mid_rst", 0, 0);
        rst = 0;
        #1 chk_rdy("post_rst", 1, 0);
        @(posedge clk); #1;
        chk_out("post_rst", 1, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_2x1_arb.md
# mux_2x1_arb

Two-input valid/ready arbiter that sits directly upstream of the 2:1 data mux. It selects one of two requesting sources, registers the chosen data into a one-entry output stage, and drives the select line `sel` consumed by the downstream mux. Throughput is one transfer per cycle, with round-robin fairness between the sources.

## Interface
- `WIDTH`, default 1: data width of each input and of the output.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in0_valid`  in  1  source 0 has data.
- `in0_data`  in  WIDTH  source 0 payload.
- `in0_ready`  out  1  source 0 transfer accepted this cycle.
- `in1_valid`  in  1  source 1 has data.
- `in1_data`  in  WIDTH  source 1 payload.
- `in1_ready`  out  1  source 1 transfer accepted this cycle.
- `out_valid`  out  1  output register holds data.
- `out_data`  out  WIDTH  registered payload.
- `out_ready`  in  1  sink accepts `out_data`.
- `sel`  out  1  source of the last accepted transfer (0 = in0, 1 = in1); the downstream mux select.

## Operation
- Two-state FSM:
  - EMPTY: `out_valid`=0.
  - FULL: `out_valid`=1.
- `load` = !out_valid || out_ready.
- Grant is combinational from in0_valid, in1_valid and `sel`:
  - Only one source valid: grant that source.
  - Both valid: grant `!sel` (round-robin).
  - Neither valid: no grant.
- `inX_ready` = load && grant==X. `inX_ready` depends on `inX_valid` only through the grant; sources must not wait for ready before asserting valid.
- On a cycle with load and a grant:
  - out_data <= granted data.
  - sel <= granted index.
  - Next state FULL.
- On a cycle with load and no grant: next state EMPTY; out_data and sel hold.
- FULL with !out_ready: everything holds. Both readies are 0.
- Simultaneous output drain and input load: the new data replaces the old in the same edge, with no bubble.
- `in0_ready` and `in1_ready` are never both 1.

## Timing
- Reset values: out_valid=0, out_data=0, sel=1 (so in0 wins the first tie). in0_ready and in1_ready are 0 while rst is high.
- Latency: input accepted on edge N, visible on out_data/out_valid after edge N.
- Sustained throughput: 1 transfer/cycle while out_ready=1.
- Tie sequence with both inputs always valid and out_ready=1: in0, in1, in0, in1, …
- Reset asserted mid-transfer: state clears immediately (asynchronous). Data in the output register is discarded and no ready is issued. The first post-reset tie goes to in0.
- Stall: out_data and sel must be stable while out_valid && !out_ready.

## Configuration
- Macro `MUX_ARB_FAIR_EN`.
  - Defined: round-robin tie-break as above.
  - Undefined: fixed priority, where in0 always wins a tie. `sel` still records the last granted source. All other behaviour is identical.

## Structure
- Package `mux_arb_pkg`:
  - FSM state typedef `arb_state_t` {ST_EMPTY, ST_FULL}.
  - Constant `SEL_RST = 1'b1`.
  - Source index constants `SRC0 = 1'b0`, `SRC1 = 1'b1`.
- Sub-module `rr_arb2`: purely combinational 2-way grant logic (req[1:0], last, grant, gnt_idx). It contains the `MUX_ARB_FAIR_EN` switch.
- Top level holds the FSM, output register and `sel` register.

## Test plan
- Reset with in0_valid=1, in1_valid=1, then release -> both readies 0 during reset; first cycle after release grants in0, in1_ready=0; out_valid=1, sel=0 on the following edge.
- Both valid for 4 cycles with out_ready=1, in0_data=1, in1_data=0 -> out_data sequence 1,0,1,0 and sel 0,1,0,1. With the macro undefined: 1,1,1,1 and sel 0.
- Only in1 valid with data 1, out_ready=1 -> in1_ready=1 every cycle; out_data=1 and sel=1 each cycle after the first.
- Output full, out_ready=0 for 3 cycles, both inputs valid -> both readies 0; out_data and sel unchanged. out_ready=1 -> drain and load in the same cycle.
- Reset asserted while FULL with out_ready=0 -> out_valid drops immediately without waiting for a clock edge, and sel returns to 1.
- Neither valid, out_ready=1 after a transfer -> out_valid goes to 0 on the next edge; out_data holds its last value.
